// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle ops plus iterative signed shift-add multiply
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       alu_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             overflow,
   output logic             illegal,
   output logic             ovf_sticky,
   input  logic             ovf_clear
);
   localparam int             CW       = $clog2(WIDTH);
   localparam logic [4:0]     CODE_MUL = 5'b00110;
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAXV   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINV   = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               last;
   logic               mul_ovf;
   logic               accept;
   logic               ovf_set;
   logic [SHW-1:0]     sh;
   logic [WIDTH-1:0]   sc_c;
   logic               sc_ovf;
   logic               sc_ill;

   assign accept = in_valid & in_ready;
   assign sh     = B[SHW-1:0];

   // Signed shift-add step: bit WIDTH-1 of the multiplier carries negative weight, so it subtracts.
   assign last     = (cnt == CW'(WIDTH - 1));
   assign addend   = mplier[0] ? mcand : '0;
   assign acc_next = last ? (acc - addend) : (acc + addend);
   assign mul_ovf  = (acc_next[2*WIDTH-1:WIDTH] != {WIDTH{acc_next[WIDTH-1]}});

   // Sticky overflow is raised on the same edge that a flagged result becomes visible.
   assign ovf_set = (state == IDLE && accept && alu_code != CODE_MUL && sc_ovf) ||
                    (state == MUL && last && mul_ovf);

   // Result of every single-cycle operation, evaluated on the presented operands.
   always_comb begin
      sc_c   = '0;
      sc_ovf = 1'b0;
      sc_ill = 1'b0;
      case (alu_code)
         5'b00000: begin
            sc_c   = A + B;
            sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sc_c[WIDTH-1] != A[WIDTH-1]);
         end
         5'b00010: begin
            sc_c   = A - B;
            sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sc_c[WIDTH-1] != A[WIDTH-1]);
         end
         5'b00100: begin
            sc_c   = A + ONE;
            sc_ovf = (A == MAXV);
         end
         5'b00101: begin
            sc_c   = A - ONE;
            sc_ovf = (A == MINV);
         end
         5'b00110: sc_c = '0;
         5'b01000: sc_c = A & B;
         5'b01001: sc_c = A | B;
         5'b01010: sc_c = A ^ B;
         5'b01100: sc_c = ~A;
         5'b10000: sc_c = A << sh;
         5'b10001: sc_c = A >> sh;
         5'b10010: sc_c = {A[WIDTH-1], A[WIDTH-2:0] << sh};
         5'b10011: sc_c = $signed(A) >>> sh;
         5'b11000: sc_c[0] = ($signed(A) <= $signed(B));
         5'b11001: sc_c[0] = ($signed(A) <  $signed(B));
         5'b11010: sc_c[0] = ($signed(A) >= $signed(B));
         5'b11011: sc_c[0] = ($signed(A) >  $signed(B));
         5'b11100: sc_c[0] = (A == B);
         5'b11101: sc_c[0] = (A != B);
         default:  sc_ill = 1'b1;
      endcase
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         C          <= '0;
         overflow   <= 1'b0;
         illegal    <= 1'b0;
         ovf_sticky <= 1'b0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (alu_code == CODE_MUL) begin
                     state  <= MUL;
                     acc    <= '0;
                     mcand  <= {{WIDTH{A[WIDTH-1]}}, A};
                     mplier <= B;
                     cnt    <= '0;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     C         <= sc_c;
                     overflow  <= sc_ovf;
                     illegal   <= sc_ill;
                  end
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  C         <= acc_next[WIDTH-1:0];
                  overflow  <= mul_ovf;
                  illegal   <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
         if (ovf_set)
            ovf_sticky <= 1'b1;
         else if (ovf_clear)
            ovf_sticky <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed WIDTH=16 checks and randomized WIDTH=32 run against a reference model
module tb_alu_seq;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;
   localparam int     NOPS = 10000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [15:0] d_a, d_b, d_c;
   logic [4:0]  d_code;
   logic        d_ovf, d_ill, d_sticky, d_clear;

   logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready;
   logic [31:0] r_a, r_b, r_c;
   logic [4:0]  r_code;
   logic        r_ovf, r_ill, r_sticky, r_clear;

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .A(d_a), .B(d_b), .alu_code(d_code), .out_valid(d_out_valid),
      .out_ready(d_out_ready), .C(d_c), .overflow(d_ovf), .illegal(d_ill),
      .ovf_sticky(d_sticky), .ovf_clear(d_clear)
   );

   alu_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .A(r_a), .B(r_b), .alu_code(r_code), .out_valid(r_out_valid),
      .out_ready(r_out_ready), .C(r_c), .overflow(r_ovf), .illegal(r_ill),
      .ovf_sticky(r_sticky), .ovf_clear(r_clear)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op on the 16-bit instance, scramble inputs afterwards, return cycles until out_valid.
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [4:0] code, output int lat);
      d_a = a; d_b = b; d_code = code; d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
      lat = 1;
      while (!d_out_valid && lat < 100) begin
         d_a = 16'($urandom); d_b = 16'($urandom); d_code = 5'($urandom);
         tick();
         lat++;
      end
   endtask

   task automatic retire16();
      d_out_ready = 1'b1;
      tick();
      d_out_ready = 1'b0;
   endtask

   // Reference behaviour computed with wide signed integer arithmetic.
   function automatic void model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] c, output logic ovf, output logic ill, output int lat);
      longint sa, sb, r, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = longint'(1) << b[4:0];
      c = '0; ovf = 1'b0; ill = 1'b0; lat = 1; r = 0;
      case (code)
         5'b00000: begin r = sa + sb; c = r[31:0]; ovf = (r > MAXS) || (r < MINS); end
         5'b00010: begin r = sa - sb; c = r[31:0]; ovf = (r > MAXS) || (r < MINS); end
         5'b00100: begin r = sa + 1;  c = r[31:0]; ovf = (r > MAXS); end
         5'b00101: begin r = sa - 1;  c = r[31:0]; ovf = (r < MINS); end
         5'b00110: begin r = sa * sb; c = r[31:0]; ovf = (r > MAXS) || (r < MINS); lat = 33; end
         5'b01000: c = a & b;
         5'b01001: c = a | b;
         5'b01010: c = a ^ b;
         5'b01100: c = ~a;
         5'b10000: begin r = longint'(a) * p; c = r[31:0]; end
         5'b10001: begin r = longint'(a) / p; c = r[31:0]; end
         5'b10010: begin r = longint'(a[30:0]) * p; c = {a[31], r[30:0]}; end
         5'b10011: begin
            r = sa / p;
            if (sa < 0 && (sa % p) != 0) r = r - 1;
            c = r[31:0];
         end
         5'b11000: c = {31'b0, sa <= sb};
         5'b11001: c = {31'b0, sa <  sb};
         5'b11010: c = {31'b0, sa >= sb};
         5'b11011: c = {31'b0, sa >  sb};
         5'b11100: c = {31'b0, sa == sb};
         5'b11101: c = {31'b0, sa != sb};
         default:  ill = 1'b1;
      endcase
   endfunction

   int          lat, exp_lat, cnt;
   logic [31:0] ra, rb, ec;
   logic [4:0]  rcode;
   logic        eovf, eill, exp_sticky;
   logic [15:0] held;

   initial begin
      rst = 1'b1;
      d_in_valid = 0; d_out_ready = 0; d_a = 0; d_b = 0; d_code = 0; d_clear = 0;
      r_in_valid = 0; r_out_ready = 0; r_a = 0; r_b = 0; r_code = 0; r_clear = 0;
      tick(); tick();
      rst = 1'b0;
      check("rst_out_valid", d_out_valid, 0);
      check("rst_C", d_c, 0);
      check("rst_ovf", d_ovf, 0);
      check("rst_ill", d_ill, 0);
      check("rst_sticky", d_sticky, 0);
      check("rst_in_ready", d_in_ready, 1);

      op16(16'h7FFF, 16'h0001, 5'b00000, lat);
      check("add_lat", lat, 1);
      check("add_C", d_c, 16'h8000);
      check("add_ovf", d_ovf, 1);
      check("add_sticky", d_sticky, 1);
      check("add_ill", d_ill, 0);
      retire16();
      d_clear = 1'b1; tick(); d_clear = 1'b0;
      check("clear_sticky", d_sticky, 0);

      op16(16'hFFFD, 16'h0005, 5'b00110, lat);
      check("mul_lat", lat, 17);
      check("mul_C", d_c, 16'hFFF1);
      check("mul_ovf", d_ovf, 0);
      check("mul_sticky0", d_sticky, 0);
      retire16();
      op16(16'h0100, 16'h0100, 5'b00110, lat);
      check("mul2_lat", lat, 17);
      check("mul2_C", d_c, 16'h0000);
      check("mul2_ovf", d_ovf, 1);
      check("mul2_sticky", d_sticky, 1);
      retire16();

      op16(16'h8010, 16'h0004, 5'b10011, lat); check("asr_C", d_c, 16'hF801); retire16();
      op16(16'h8010, 16'h0004, 5'b10010, lat); check("asl_C", d_c, 16'h8100); retire16();
      op16(16'h8010, 16'h0004, 5'b10001, lat); check("lsr_C", d_c, 16'h0801); retire16();
      op16(16'h8010, 16'h0000, 5'b10011, lat); check("asr_s0_C", d_c, 16'h8010); retire16();
      op16(16'h8000, 16'h7FFF, 5'b11001, lat); check("lt_C", d_c, 16'h0001); retire16();
      op16(16'h8000, 16'h7FFF, 5'b11011, lat); check("gt_C", d_c, 16'h0000); retire16();
      op16(16'h8000, 16'h7FFF, 5'b11100, lat); check("eq_C", d_c, 16'h0000); retire16();
      op16(16'h8000, 16'h0001, 5'b00101, lat);
      check("dec_C", d_c, 16'h7FFF);
      check("dec_ovf", d_ovf, 1);
      retire16();
      op16(16'h1234, 16'h5678, 5'b01111, lat);
      check("ill_lat", lat, 1);
      check("ill_C", d_c, 16'h0000);
      check("ill_flag", d_ill, 1);
      check("ill_ovf", d_ovf, 0);
      retire16();

      // Set and clear on the same edge: set wins.
      d_clear = 1'b1;
      op16(16'h7FFF, 16'h0001, 5'b00000, lat);
      d_clear = 1'b0;
      check("set_prio_sticky", d_sticky, 1);
      retire16();

      // Back-pressure: result holds while inputs churn.
      op16(16'h0001, 16'h0002, 5'b00000, lat);
      held = d_c;
      check("hold_C0", held, 16'h0003);
      for (int i = 0; i < 5; i++) begin
         d_in_valid = 1'($urandom); d_a = 16'($urandom); d_b = 16'($urandom);
         tick();
         check("hold_C", d_c, 16'h0003);
         check("hold_in_ready", d_in_ready, 0);
         check("hold_out_valid", d_out_valid, 1);
      end
      d_in_valid = 1'b0;
      retire16();
      check("after_in_ready", d_in_ready, 1);
      tick();
      check("no_queue_out_valid", d_out_valid, 0);

      // Reset aborts a multiply in flight.
      d_a = 16'h0003; d_b = 16'h0004; d_code = 5'b00110; d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("abort_in_ready", d_in_ready, 1);
      check("abort_out_valid", d_out_valid, 0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (d_out_valid) cnt++;
      end
      check("abort_never_valid", cnt, 0);

      // Randomized WIDTH=32 run with stalls.
      exp_sticky = 1'b0;
      for (int n = 0; n < NOPS; n++) begin
         ra = $urandom; rb = $urandom; rcode = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         if ($urandom_range(0, 9) == 0) begin
            r_clear = 1'b1; tick(); r_clear = 1'b0;
            exp_sticky = 1'b0;
         end
         while ($urandom_range(0, 3) == 0) tick();
         check("r_in_ready", r_in_ready, 1);
         r_a = ra; r_b = rb; r_code = rcode; r_in_valid = 1'b1;
         tick();
         model(rcode, ra, rb, ec, eovf, eill, exp_lat);
         lat = 1;
         while (!r_out_valid && lat < 100) begin
            r_in_valid = 1'($urandom); r_a = $urandom; r_b = $urandom; r_code = 5'($urandom);
            tick();
            lat++;
         end
         exp_sticky = exp_sticky | eovf;
         check("r_lat", lat, exp_lat);
         check("r_C", r_c, ec);
         check("r_ovf", r_ovf, eovf);
         check("r_ill", r_ill, eill);
         check("r_sticky", r_sticky, exp_sticky);
         while ($urandom_range(0, 3) == 0) begin
            r_in_valid = 1'($urandom); r_a = $urandom;
            tick();
            check("r_stall_C", r_c, ec);
         end
         r_out_ready = 1'b1;
         tick();
         r_out_ready = 1'b0;
         r_in_valid = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
